// File: rtl/softmax_stream.sv
// softmax_stream: multi-beat log2-domain softmax; define SOFTMAX_STREAM_ROUND_EN for round-to-nearest exp2
module softmax_stream #(
  parameter int N = 8,
  parameter int DW = 16,
  parameter int FRAC = 12,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_keep,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic            out_last,
  output logic            overflow,
  output logic            busy
);
  localparam int AW = $clog2(MAX_BEATS);
  localparam int CW = AW + 1;
  localparam int SW = FRAC + 2 + $clog2(MAX_BEATS * N);
  localparam int LW = FRAC + $clog2(SW);
  localparam int TW = DW + 3;
  localparam int EW = DW + 8;
  typedef enum logic [2:0] {IDLE, LOAD, SUM, LOG, OUT} state_t;
  state_t state_q;
  logic [N*DW-1:0] mem_data [MAX_BEATS];
  logic [N-1:0] mem_keep [MAX_BEATS];
  logic [N*DW-1:0] rdata_q, ob, out_data_q;
  logic [N-1:0] rkeep_q;
  logic [CW-1:0] cnt_q, nb_q;
  logic [AW-1:0] raddr, waddr;
  logic signed [DW-1:0] max_q, bmax;
  logic [SW-1:0] s_q, esum;
  logic [LW-1:0] l_q, l_d;
  logic signed [DW:0] d;
  logic signed [TW-1:0] t;
  logic signed [EW-1:0] v;
  logic out_valid_q, out_last_q, ovf_q, acc, wr, load;
  int p;

  function automatic logic [FRAC:0] exp2(input logic signed [EW-1:0] x);
    logic [EW-1:0] s;
    logic [FRAC+2:0] m;
    s = -(x >>> FRAC);
    m = {3'b001, x[FRAC-1:0]};
`ifdef SOFTMAX_STREAM_ROUND_EN
    if (s != '0 && s <= EW'(FRAC + 1)) m = m + ((FRAC+3)'(1) << (s - EW'(1)));
`endif
    m = m >> s;
    return (s > EW'(FRAC + 1)) ? '0 : (m > (FRAC+3)'(1 << FRAC)) ? (FRAC+1)'(1 << FRAC) : m[FRAC:0];
  endfunction

  assign in_ready = state_q == IDLE || state_q == LOAD;
  assign acc = in_valid && in_ready && en;
  assign wr = acc && (state_q == IDLE || nb_q < CW'(MAX_BEATS));
  assign waddr = state_q == IDLE ? '0 : nb_q[AW-1:0];
  assign load = state_q == OUT && cnt_q < nb_q && (!out_valid_q || out_ready);
  assign raddr = state_q == SUM ? cnt_q[AW-1:0] : state_q == OUT ? AW'(cnt_q + CW'(load)) : '0;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;

  // running max over kept lanes; the first beat starts from the most negative value
  always_comb begin
    bmax = state_q == IDLE ? {1'b1, {(DW-1){1'b0}}} : max_q;
    for (int i = 0; i < N; i++)
      bmax = (in_keep[i] && $signed(in_data[i*DW +: DW]) > bmax) ? in_data[i*DW +: DW] : bmax;
  end

  // per-lane exp2 terms: summed during SUM, normalised by L during OUT
  always_comb begin
    esum = '0;
    ob = '0;
    d = '0;
    t = '0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      d = $signed({rdata_q[i*DW+DW-1], rdata_q[i*DW +: DW]}) - $signed({max_q[DW-1], max_q});
      t = TW'(d) + TW'(d >>> 1) - TW'(d >>> 4);
      esum = esum + (rkeep_q[i] ? SW'(exp2(EW'(t))) : '0);
      v = EW'(t) - $signed(EW'(l_q));
      ob[i*DW +: DW] = rkeep_q[i] ? DW'(exp2(v)) : '0;
    end
  end

  // Mitchell log2 of the sum: integer part from the leading one, mantissa bits below it
  always_comb begin
    p = FRAC;
    for (int i = FRAC; i < SW; i++) p = s_q[i] ? i : p;
    l_d = {(LW-FRAC)'(p - FRAC), FRAC'(s_q >> (p - FRAC))};
  end

  // vector buffer with a registered read port that tracks the next read address
  always_ff @(posedge clk)
    if (en) begin
      if (wr) begin
        mem_data[waddr] <= in_data;
        mem_keep[waddr] <= in_keep;
      end
      rdata_q <= mem_data[raddr];
      rkeep_q <= mem_keep[raddr];
    end

  // control FSM: load, sum pass, log, output pass with a single output register
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nb_q <= '0;
      max_q <= '0;
      s_q <= '0;
      l_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (en) begin
      case (state_q)
        IDLE: if (acc) begin
          nb_q <= CW'(1);
          cnt_q <= '0;
          s_q <= '0;
          max_q <= bmax;
          ovf_q <= 1'b0;
          state_q <= in_last ? SUM : LOAD;
        end
        LOAD: if (acc) begin
          if (wr) begin
            nb_q <= nb_q + CW'(1);
            max_q <= bmax;
          end else ovf_q <= 1'b1;
          if (in_last) state_q <= SUM;
        end
        SUM: begin
          if (cnt_q != '0) s_q <= s_q + esum;
          cnt_q <= cnt_q == nb_q ? '0 : cnt_q + CW'(1);
          if (cnt_q == nb_q) state_q <= LOG;
        end
        LOG: begin
          l_q <= l_d;
          state_q <= OUT;
        end
        OUT: if (load) begin
          out_data_q <= ob;
          out_valid_q <= 1'b1;
          out_last_q <= cnt_q == nb_q - CW'(1);
          cnt_q <= cnt_q + CW'(1);
        end else if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
          out_last_q <= 1'b0;
          if (out_last_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/softmax_stream.md
Name: softmax_stream

Overview:
- Streaming, multi-beat softmax engine: accepts a vector of up to MAX_BEATS*N Q4.12 elements, N lanes per beat, over a valid/ready handshake.
- Buffers the vector internally and computes the max itself. Applies the log2-domain approximation: exp2 of (x-max)*log2e, sum, Mitchell log2, then exp2 of (t-log2sum).
- Streams probabilities out N lanes per beat.
- Sits between the attention score producer and the probability consumer, replacing the single-beat, externally-maxed softmax.

Parameters:
N, 8, lanes per beat
DW, 16, element width (signed fixed point)
FRAC, 12, fractional bits
MAX_BEATS, 16, buffer depth in beats (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  global enable; when low, all state, registers and outputs hold
in_valid  in  1  input beat valid
in_ready  out  1  high only in IDLE/LOAD
in_data  in  N*DW  lane i at [i*DW +: DW]
in_keep  in  N  lane valid mask; masked lanes excluded from max/sum, output 0
in_last  in  1  final beat of vector
out_valid  out  1  output beat valid
out_ready  in  1  consumer ready
out_data  out  N*DW  probabilities, Q(DW-FRAC).FRAC, value in [0, 1.0]
out_last  out  1  final output beat
overflow  out  1  sticky; vector exceeded MAX_BEATS; cleared on next vector's first accepted beat
busy  out  1  state != IDLE

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, overflow=0, busy=0. Reset goes to IDLE. Reset mid-vector discards the vector; in_ready=1 on the first cycle after rst deasserts.
- Handshake: a transfer occurs on a cycle with valid&ready&en. out_data/out_last hold stable while out_valid&!out_ready.
- State IDLE: first accepted beat → LOAD. The beat is written to buffer[0]; running max initialises to the max of its kept lanes.
- State LOAD: each accepted beat is written to buffer[wptr]; wptr increments. Running max covers kept lanes only. A beat with no kept lanes leaves max unchanged.
  - If beat count exceeds MAX_BEATS, extra beats are accepted and dropped, and overflow sets.
  - The in_last transfer → SUM, with B = min(beats, MAX_BEATS).
  - An all-masked vector outputs B beats of zeros.
- State SUM: lasts B+1 cycles (synchronous buffer read). For each kept element:
  - d = x - max, (DW+1)-bit signed.
  - t = d + (d>>>1) - (d>>>4), arithmetic shifts, (DW+3)-bit. This approximates log2e = 1.4375.
  - e = exp2(t), accumulated into S of width FRAC+2+clog2(MAX_BEATS*N).
- State LOG: 1 cycle.
  - p = index of the leading one of S; p >= FRAC is guaranteed since the max element gives e = 2^FRAC.
  - L = ((p-FRAC) << FRAC) | S[p-1 : p-FRAC].
- State OUT: re-reads the buffer. Per kept lane, out = exp2(t - L); masked lanes output 0.
  - First out_valid occurs exactly B+4 cycles after the in_last transfer cycle.
  - Subsequent beats follow back-to-back when out_ready=1.
  - out_last accompanies beat B. Its transfer → IDLE, with in_ready=1 the next cycle.
- exp2(v), v <= 0:
  - k = floor(v >> FRAC), f = v - (k << FRAC), s = -k.
  - Result = (2^FRAC + f) >> s, truncating.
  - Result = 0 when s > FRAC+1; result = 2^FRAC when v = 0.
- Simultaneous events: rst has priority over en and all handshakes. en=0 freezes the FSM, counters and accumulators mid-pass.

Optional Feature:
- Macro SOFTMAX_STREAM_ROUND_EN.
- Defined: exp2 rounds to nearest, (2^FRAC + f + (1<<(s-1))) >> s for s >= 1, saturated at 2^FRAC.
- Undefined: truncating shift as specified above.
- Latency is identical either way.
- Test values below assume the macro is undefined.

Test Plan:
1. One beat, all lanes 0x0000, keep=0xFF, in_last=1 → S=32768, L=0x3000; one output beat, every lane 0x0200, out_last=1; first out_valid exactly 5 cycles after the input transfer.
2. One beat, lane0=0x1000, lanes1-7=0x0000 → non-max e=1600, S=15296, L=7648; out lane0=1160 (0x0488), lanes1-7=434 (0x01B2).
3. keep=0x0F, lanes0-3=0x0000, lanes4-7=0x7FFF → max ignores masked lanes; S=16384, L=0x2000; out lanes0-3=0x0400, lanes4-7=0x0000.
4. 4-beat vector of zeros, out_ready low for 3 cycles after the 2nd output beat → out_data/out_valid held; 4 beats of 0x0080 per lane, out_last on beat 4 only; in_ready=0 throughout SUM/LOG/OUT.
5. MAX_BEATS=4, 6 beats sent → all 6 accepted, overflow=1, exactly 4 output beats with out_last on the 4th; overflow clears on the next vector's first beat.
6. rst pulsed during OUT → out_valid=0, busy=0, in_ready=1 next cycle; a subsequent zero vector reproduces test 1.
